// File: rtl/conv_l1_window_sched.sv
// Raster-order 3x3 window sequencer for the layer-1 convolution array.
// Emits a window at stride-S positions, decided purely from pixel row/column counters.
module conv_l1_window_sched #(
  parameter int F = 28,
  parameter int B = 8,
  parameter int S = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [B-1:0]         i_pixel,
  input  logic                 i_pixel_valid,
  output logic                 o_pixel_ready,
  output logic [9*B-1:0]       o_window,
  output logic                 o_window_valid,
  output logic [$clog2(F)-1:0] o_out_x,
  output logic [$clog2(F)-1:0] o_out_y,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int CW = $clog2(F);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] row, col;
  logic          accept, last_col, emit;
  logic [B-1:0]  line_a [F];
  logic [B-1:0]  line_b [F];
  logic [B-1:0]  win [3][3];

  assign accept   = i_pixel_valid && o_pixel_ready;
  assign last_col = (col == CW'(F - 1));
  // With S=2, (n-2) mod 2 == 0 is simply n even.
  assign emit     = accept && (row >= CW'(2)) && (col >= CW'(2)) &&
                    (S == 1 || (!row[0] && !col[0]));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = LOAD;
      LOAD: if (accept && row == CW'(1) && last_col) state_nxt = RUN;
      RUN:  if (accept && row == CW'(F - 1) && last_col) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_pixel_ready = (state == LOAD) || (state == RUN);
    o_busy        = (state != IDLE);
    o_frame_done  = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (state == IDLE && i_start)) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= (row == CW'(F - 1)) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // NOTE: delay lines are not reset; stale contents can never reach an emitted window (r>=2, c>=2).
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_a[0] <= i_pixel;
      line_b[0] <= line_a[F-1];
      for (int i = 1; i < F; i++) begin
        line_a[i] <= line_a[i-1];
        line_b[i] <= line_b[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          win[k][j] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 2; j++)
          win[k][j] <= win[k][j+1];
      win[0][2] <= line_b[F-1];
      win[1][2] <= line_a[F-1];
      win[2][2] <= i_pixel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_window_valid <= 1'b0;
      o_out_x        <= '0;
      o_out_y        <= '0;
    end else begin
      o_window_valid <= emit;
      if (emit) begin
        o_out_x <= (S == 2) ? ((col - CW'(2)) >> 1) : (col - CW'(2));
        o_out_y <= (S == 2) ? ((row - CW'(2)) >> 1) : (row - CW'(2));
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        o_window[B*(3*k+j) +: B] = win[k][j];
  end

endmodule

// File: tb/tb_conv_l1_window_sched.sv
// Scoreboard bench for conv_l1_window_sched; an S=1 and an S=2 instance see identical stimulus.
module tb_conv_l1_window_sched;

  localparam int F  = 28;
  localparam int B  = 8;
  localparam int CW = $clog2(F);
  localparam int WIN_S1 = (F - 3) / 1 + 1;
  localparam int WIN_S2 = (F - 3) / 2 + 1;

  typedef struct {
    logic [9*B-1:0] win;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    int             due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, pixel_valid;
  logic [B-1:0]   pixel;
  logic           ready  [2];
  logic [9*B-1:0] window [2];
  logic           wvalid [2];
  logic [CW-1:0]  out_x  [2];
  logic [CW-1:0]  out_y  [2];
  logic           busy   [2];
  logic           done   [2];

  exp_t sbq [2][$];
  int   checks = 0, failures = 0, cycle = 0;
  int   wcount [2], done_cnt [2], last_x [2], last_y [2];
  logic s_ready [2];
  bit   prev_acc = 1'b0;

  always #5 clk = ~clk;

  conv_l1_window_sched #(.F(F), .B(B), .S(1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pixel(pixel), .i_pixel_valid(pixel_valid),
    .o_pixel_ready(ready[0]), .o_window(window[0]), .o_window_valid(wvalid[0]),
    .o_out_x(out_x[0]), .o_out_y(out_y[0]), .o_busy(busy[0]), .o_frame_done(done[0]));

  conv_l1_window_sched #(.F(F), .B(B), .S(2)) dut_s2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pixel(pixel), .i_pixel_valid(pixel_valid),
    .o_pixel_ready(ready[1]), .o_window(window[1]), .o_window_valid(wvalid[1]),
    .o_out_x(out_x[1]), .o_out_y(out_y[1]), .o_busy(busy[1]), .o_frame_done(done[1]));

  function automatic logic [B-1:0] pix(input int r, input int c, input int off);
    return B'((r * F + c + off) % 256);
  endfunction

  function automatic void push_expect(input int r, input int c, input int off, input int due);
    exp_t e;
    int   s;
    for (int d = 0; d < 2; d++) begin
      s = d + 1;
      if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
        for (int k = 0; k < 3; k++)
          for (int j = 0; j < 3; j++)
            e.win[B*(3*k+j) +: B] = pix(r - 2 + k, c - 2 + j, off);
        e.x   = CW'((c - 2) / s);
        e.y   = CW'((r - 2) / s);
        e.due = due;
        sbq[d].push_back(e);
      end
    end
  endfunction

  // One clock: sample and score outputs on the falling edge, return at rising edge + 1.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    cycle++;
    for (int d = 0; d < 2; d++) begin
      s_ready[d] = ready[d];
      if (done[d]) done_cnt[d]++;
      if (wvalid[d]) begin
        checks++;
        if (!prev_acc) begin
          failures++;
          $display("FAIL win_no_accept dut_s%0d cycle=%0d window_valid=1 required=0", d + 1, cycle);
        end
        checks++;
        if (sbq[d].size() == 0) begin
          failures++;
          $display("FAIL win_unexpected dut_s%0d cycle=%0d x=%0d y=%0d required=no window",
                   d + 1, cycle, out_x[d], out_y[d]);
        end else begin
          e = sbq[d].pop_front();
          if (window[d] !== e.win || out_x[d] !== e.x || out_y[d] !== e.y || cycle != e.due) begin
            failures++;
            $display("FAIL window dut_s%0d cycle=%0d got win=%h x=%0d y=%0d required win=%h x=%0d y=%0d cycle=%0d",
                     d + 1, cycle, window[d], out_x[d], out_y[d], e.win, e.x, e.y, e.due);
          end
          wcount[d]++;
          last_x[d] = int'(out_x[d]);
          last_y[d] = int'(out_y[d]);
        end
      end
    end
    acc      = pixel_valid && ready[1];
    prev_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int off, input bit gaps, input int n, input int start_at);
    bit acc;
    int budget, r, c;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / F;
      c = idx % F;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pixel_valid = 1'b0;
          pixel       = B'($urandom);
          tick(acc);
        end
      end
      pixel_valid = 1'b1;
      pixel       = pix(r, c, off);
      start       = (idx == start_at);
      acc         = 1'b0;
      budget      = 0;
      while (!acc) begin
        tick(acc);
        start = 1'b0;
        if (acc) push_expect(r, c, off, cycle + 1);
        else if (++budget > 20) begin
          checks++;
          failures++;
          $display("FAIL pixel_stall pixel=(%0d,%0d) ready=0 required=1", r, c);
          pixel_valid = 1'b0;
          return;
        end
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic begin_frame(input bit valid_in_idle);
    bit acc;
    pixel_valid = valid_in_idle;
    pixel       = 8'hA5;
    start       = 1'b1;
    tick(acc);
    start       = 1'b0;
    pixel_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_idle dut_s%0d got=%b required=0", d + 1, s_ready[d]);
      end
      checks++;
      if (busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL busy_rise dut_s%0d got=%b required=1", d + 1, busy[d]);
      end
      wcount[d]   = 0;
      done_cnt[d] = 0;
    end
  endtask

  task automatic end_frame();
    bit acc;
    int req;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({done[d], busy[d], ready[d]} !== 3'b110) begin
        failures++;
        $display("FAIL done_pulse dut_s%0d done/busy/ready got=%b%b%b required=110",
                 d + 1, done[d], busy[d], ready[d]);
      end
    end
    tick(acc);
    for (int d = 0; d < 2; d++) begin
      req = (d == 0) ? WIN_S1 * WIN_S1 : WIN_S2 * WIN_S2;
      checks++;
      if ({done[d], busy[d]} !== 2'b00) begin
        failures++;
        $display("FAIL done_fall dut_s%0d done/busy got=%b%b required=00", d + 1, done[d], busy[d]);
      end
      checks++;
      if (wcount[d] != req || sbq[d].size() != 0 || done_cnt[d] != 1) begin
        failures++;
        $display("FAIL frame_count dut_s%0d windows=%0d pending=%0d done_pulses=%0d required %0d/0/1",
                 d + 1, wcount[d], sbq[d].size(), done_cnt[d], req);
      end
      checks++;
      if (last_x[d] != ((d == 0) ? WIN_S1 - 1 : WIN_S2 - 1) || last_y[d] != last_x[d]) begin
        failures++;
        $display("FAIL last_window dut_s%0d x=%0d y=%0d required x=y=%0d",
                 d + 1, last_x[d], last_y[d], (d == 0) ? WIN_S1 - 1 : WIN_S2 - 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ready[d], wvalid[d], busy[d], done[d]} !== 4'b0 || window[d] !== '0 ||
          out_x[d] !== '0 || out_y[d] !== '0) begin
        failures++;
        $display("FAIL %s dut_s%0d ready=%b wvalid=%b busy=%b done=%b win=%h x=%0d y=%0d required all 0",
                 tag, d + 1, ready[d], wvalid[d], busy[d], done[d], window[d], out_x[d], out_y[d]);
      end
    end
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel = '0;
    tick(acc);
    tick(acc);
    check_all_zero("reset_state");
    start = 1'b1;
    tick(acc);
    start = 1'b0;
    check_all_zero("reset_beats_start");
    rst = 1'b0;
    tick(acc);
  endtask

  task automatic test_ramp();
    begin_frame(1'b0);
    send_pixels(0, 1'b0, F * F, -1);
    end_frame();
  endtask

  task automatic test_gaps();
    begin_frame(1'b0);
    send_pixels(0, 1'b1, F * F, -1);
    end_frame();
  endtask

  task automatic test_start_ignored();
    bit acc;
    pixel_valid = 1'b1;
    pixel       = 8'h5A;
    repeat (3) begin
      tick(acc);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (s_ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
          failures++;
          $display("FAIL idle_hold dut_s%0d ready=%b busy=%b required 0 0", d + 1, s_ready[d], busy[d]);
        end
      end
    end
    begin_frame(1'b1);
    send_pixels(3, 1'b0, F * F, 400);
    end_frame();
  endtask

  task automatic test_back_to_back();
    repeat (2) begin
      begin_frame(1'b0);
      send_pixels(5, 1'b0, F * F, -1);
      end_frame();
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    int snap [2];
    begin_frame(1'b0);
    send_pixels(9, 1'b0, 10 * F + 5, -1);
    pixel_valid = 1'b1;
    pixel       = pix(10, 5, 9);
    rst         = 1'b1;
    tick(acc);
    rst         = 1'b0;
    pixel_valid = 1'b0;
    check_all_zero("reset_mid_frame");
    for (int d = 0; d < 2; d++) begin
      snap[d] = done_cnt[d];
      checks++;
      if (sbq[d].size() != 0) begin
        failures++;
        $display("FAIL reset_pending dut_s%0d pending=%0d required=0", d + 1, sbq[d].size());
      end
    end
    pixel_valid = 1'b1;
    repeat (4) tick(acc);
    pixel_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done_cnt[d] != snap[d] || busy[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done dut_s%0d done_pulses=%0d busy=%b required %0d 0",
                 d + 1, done_cnt[d], busy[d], snap[d]);
      end
    end
    begin_frame(1'b0);
    send_pixels(9, 1'b0, F * F, -1);
    end_frame();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cycle=%0d required finish", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
